// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path.
//   tx_state_e   : frame sequencer states
//   PAR_*        : parity mode encodings for the PARITY parameter
//   parity_bit() : parity of a data word, zero-padded to MAX_DATABITS
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int MAX_DATABITS = 9;

  // Zero padding does not change the XOR, so narrower words can be passed
  // in after a width cast.
  function automatic logic parity_bit(input logic [MAX_DATABITS-1:0] d, input int mode);
    return (mode == PAR_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmit serializer. Accepts one word over valid/ready while idle and
// shifts it out LSB-first: start bit, DATABITS data bits, optional parity,
// STOPBITS stop bits. Bit timing comes from an external oversample tick.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   tick   in   one-clk pulse at OVERSAMPLE x baud
//   data   in   word to send, sampled only on accept
//   valid  in   data is valid
//   ready  out  high only while idle
//   tx     out  registered serial line, idles high
//   busy   out  frame in progress (!ready)
//
// States:
//   ST_IDLE   | line high, waiting for valid
//   ST_START  | start bit (0)
//   ST_DATA   | data bits, LSB first from shift register bit 0
//   ST_PARITY | parity bit
//   ST_STOP   | stop bit(s), line high
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATABITS   = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOPBITS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [DATABITS-1:0] data,
  input  logic                valid,
  output logic                ready,
  output logic                tx,
  output logic                busy
);

  if (DATABITS < 5 || DATABITS > MAX_DATABITS) begin : g_bad_databits
    $error("uart_tx: DATABITS must be in 5..9");
  end
  if (OVERSAMPLE < 2) begin : g_bad_oversample
    $error("uart_tx: OVERSAMPLE must be at least 2");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOPBITS < 1 || STOPBITS > 2) begin : g_bad_stopbits
    $error("uart_tx: STOPBITS must be 1 or 2");
  end

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATABITS);

  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATABITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOPBITS - 1);

  tx_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATABITS-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              bit_end;

  assign bit_end = tick && (cnt_q == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;

    // Ticks only advance an active frame; a tick coincident with accept is
    // dropped because the sequencer is still idle in that cycle.
    if (state_q != ST_IDLE && tick) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          state_d = ST_START;
          shreg_d = data;
          par_d   = parity_bit(MAX_DATABITS'(data), PARITY);
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        // idx is reused to count stop bits
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line is driven from the current state, so each bit appears on tx
  // one clk after the edge that entered it.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_q[0];
      ST_PARITY: tx_d = par_q;
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx    = tx_q;
  assign ready = (state_q == ST_IDLE);
  assign busy  = ~ready;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx_w[3];
  logic       ready_w[3];
  logic       busy_w[3];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  // inst0: 8 bits, x16, no parity, 1 stop
  // inst1: 8 bits, x2 (minimum), even parity, 1 stop
  // inst2: 5 bits, x4, odd parity, 2 stop
  uart_tx #(.DATABITS(8), .OVERSAMPLE(16), .PARITY(0), .STOPBITS(1)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .data(data_in), .valid(valid),
    .ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
  uart_tx #(.DATABITS(8), .OVERSAMPLE(2), .PARITY(2), .STOPBITS(1)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .data(data_in), .valid(valid),
    .ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
  uart_tx #(.DATABITS(5), .OVERSAMPLE(4), .PARITY(1), .STOPBITS(2)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .data(data_in[4:0]), .valid(valid),
    .ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

  function automatic int ovs_of(int i);
    case (i) 0: return 16; 1: return 2; default: return 4; endcase
  endfunction
  function automatic int db_of(int i);
    case (i) 0: return 8; 1: return 8; default: return 5; endcase
  endfunction
  function automatic int par_of(int i);
    case (i) 0: return 0; 1: return 2; default: return 1; endcase
  endfunction
  function automatic int stop_of(int i);
    case (i) 0: return 1; 1: return 1; default: return 2; endcase
  endfunction

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is a list of line levels, one per bit period.
  // While a frame is active, k counts ticks since accept; the level on the
  // line is the entry at k/OVERSAMPLE, seen one clk late.
  bit m_active[3];
  int m_k[3];
  bit m_frame[3][16];
  int m_nbits[3];
  bit m_line[3];
  bit m_sample[3];
  int m_epoch[3];
  bit model_ok = 1'b0;

  bit cap[3][16];
  int cap_n[3];
  int cap_epoch[3];

  task automatic build_frame(int i, logic [7:0] d);
    int db;
    int ones;
    int n;
    db   = db_of(i);
    ones = 0;
    m_frame[i][0] = 1'b0;
    for (int b = 0; b < db; b++) begin
      m_frame[i][1 + b] = d[b];
      ones += int'(d[b]);
    end
    n = 1 + db;
    if (par_of(i) == 2) begin
      m_frame[i][n] = (ones % 2) == 1;
      n++;
    end else if (par_of(i) == 1) begin
      m_frame[i][n] = (ones % 2) == 0;
      n++;
    end
    for (int s = 0; s < stop_of(i); s++) begin
      m_frame[i][n] = 1'b1;
      n++;
    end
    m_nbits[i] = n;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_active[i] = 1'b0; m_k[i] = 0; m_line[i] = 1'b1; m_sample[i] = 1'b0;
      m_epoch[i] = 0; m_nbits[i] = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        m_sample[i] = 1'b0;
        if (rst) begin
          m_active[i] = 1'b0;
          m_k[i]      = 0;
          m_line[i]   = 1'b1;
          m_epoch[i]++;
        end else begin
          m_line[i] = m_active[i] ? m_frame[i][m_k[i] / ovs_of(i)] : 1'b1;
          if (m_active[i]) begin
            if (tick) begin
              m_k[i]++;
              if (m_k[i] == ovs_of(i) * m_nbits[i]) m_active[i] = 1'b0;
              else if (m_k[i] % ovs_of(i) == ovs_of(i) / 2) m_sample[i] = 1'b1;
            end
          end else if (valid) begin
            build_frame(i, data_in);
            m_active[i] = 1'b1;
            m_k[i]      = 0;
            m_epoch[i]++;
          end
        end
      end
      if (rst) model_ok = 1'b1;
    end
  end

  // Compare process: every cycle, plus mid-bit capture of the line for the
  // literal frame checks below.
  initial begin
    for (int i = 0; i < 3; i++) begin
      cap_n[i] = 0; cap_epoch[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (model_ok) begin
        for (int i = 0; i < 3; i++) begin
          check($sformatf("tx%0d", i), int'(tx_w[i]), int'(m_line[i]));
          check($sformatf("ready%0d", i), int'(ready_w[i]), int'(!m_active[i]));
          check($sformatf("busy%0d", i), int'(busy_w[i]), int'(m_active[i]));
          if (cap_epoch[i] != m_epoch[i]) begin
            cap_epoch[i] = m_epoch[i];
            cap_n[i]     = 0;
          end
          if (m_sample[i] && cap_n[i] < 16) begin
            cap[i][cap_n[i]] = tx_w[i];
            cap_n[i]++;
          end
        end
      end
    end
  end

  function automatic int cap_val(int i);
    int v;
    v = 0;
    for (int j = 0; j < cap_n[i] && j < 16; j++) v |= int'(cap[i][j]) << j;
    return v;
  endfunction

  task automatic check_cap(string name, int i, int exp_val, int exp_n);
    check({name, "_bits"}, cap_val(i), exp_val);
    check({name, "_len"}, cap_n[i], exp_n);
  endtask

  int tick_period = 4;
  int phase = 0;

  task automatic cyc();
    @(negedge clk);
    if (tick_period > 0) begin
      tick  = (phase == 0);
      phase = (phase + 1) % tick_period;
    end else begin
      tick = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic wait_all_idle(int limit);
    int g;
    g = 0;
    while (!(ready_w[0] && ready_w[1] && ready_w[2]) && g < limit) begin
      cyc();
      g++;
    end
    check("all_idle", int'(ready_w[0] && ready_w[1] && ready_w[2]), 1);
  endtask

  task automatic send(logic [7:0] d);
    data_in = d;
    valid   = 1'b1;
    cyc();
    valid   = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin : stim
    int g;
    int nticks;

    rst = 1'b1;
    cyc();
    cyc();
    check("rst_tx0", int'(tx_w[0]), 1);
    check("rst_ready0", int'(ready_w[0]), 1);
    check("rst_busy0", int'(busy_w[0]), 0);
    rst = 1'b0;
    repeat (3) cyc();

    // 0x55, tick every 4 clk: alternating line, 160 ticks to ready
    send(8'h55);
    nticks = 0;
    g = 0;
    while (!ready_w[0] && g < 4000) begin
      nticks += int'(tick);
      cyc();
      g++;
    end
    check("frame_ticks0", nticks, 160);
    wait_all_idle(4000);
    check_cap("f55_0", 0, 'h2AA, 10);
    repeat (2) cyc();

    // 0xA3: even parity 0 on inst1, odd parity 1 on the 5-bit inst2
    send(8'hA3);
    wait_all_idle(4000);
    check_cap("fA3_0", 0, 'h346, 10);
    check_cap("fA3_1", 1, 'h546, 11);
    check("par_even_1", int'(cap[1][9]), 0);
    check_cap("fA3_2", 2, 'h1C6, 9);
    check("par_odd_2", int'(cap[2][6]), 1);
    repeat (2) cyc();

    // valid pulsed mid-frame with different data: ignored, no re-sample
    send(8'hC3);
    g = 0;
    while (m_k[0] < 20 && g < 2000) begin cyc(); g++; end
    data_in = 8'h00;
    valid   = 1'b1;
    cyc();
    valid   = 1'b0;
    wait_all_idle(4000);
    check_cap("fC3_0", 0, 902, 10);
    repeat (20) cyc();
    check("no_second_frame0", int'(ready_w[0]), 1);

    // back-to-back with valid held: 1 clk of ready between frames
    data_in = 8'h12;
    valid   = 1'b1;
    g = 0;
    while (!busy_w[0] && g < 100) begin cyc(); g++; end
    data_in = 8'h34;
    g = 0;
    while (!ready_w[0] && g < 4000) begin cyc(); g++; end
    check("b2b_ready_seen", int'(ready_w[0]), 1);
    cyc();
    check("b2b_reaccept", int'(busy_w[0]), 1);
    valid = 1'b0;
    wait_all_idle(4000);
    check_cap("f34_0", 0, 616, 10);
    repeat (2) cyc();

    // reset during data bit 3 abandons the frame at once
    send(8'h81);
    g = 0;
    while (m_k[0] < 68 && g < 2000) begin cyc(); g++; end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rstmid_tx0", int'(tx_w[0]), 1);
    check("rstmid_ready0", int'(ready_w[0]), 1);
    cyc();
    send(8'h81);
    wait_all_idle(4000);
    check_cap("f81_0", 0, 770, 10);

    // random traffic, random tick spacing, occasional reset
    tick_period = 0;
    for (int c = 0; c < 3000; c++) begin
      valid   = ($urandom_range(0, 3) == 0);
      data_in = 8'($urandom_range(0, 255));
      rst     = ($urandom_range(0, 699) == 0);
      cyc();
    end
    rst = 1'b0;
    // tick on every clk
    tick_period = 1;
    for (int c = 0; c < 1000; c++) begin
      valid   = ($urandom_range(0, 1) == 0);
      data_in = 8'($urandom_range(0, 255));
      cyc();
    end
    valid = 1'b0;
    wait_all_idle(4000);
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
